axis_mux_pkt_n: RTL and testbench
=================================

// Module: axis_mux_pkt_n
// PURPOSE
//  N-input AXI4-Stream mux, frame-aware. Switches inputs only at packet boundaries.
//  Selects by explicit sel (MODE 0) or round-robin among valid inputs (MODE 1).
//  Output is registered through a 2-entry skid buffer, sustaining 1 beat/cycle.
//  Used where several stream sources (DMA, generators) share one downstream sink.
// PARAMETERS
//  S_COUNT      4     number of input ports (>=2)
//  DATA_WIDTH   32    tdata width, bits
//  KEEP_ENABLE  (DATA_WIDTH>8)  propagate tkeep; 0 -> m tkeep all-ones
//  KEEP_WIDTH   (DATA_WIDTH/8)  tkeep width
//  ID_ENABLE    0     propagate tid; 0 -> m tid = 0
//  ID_WIDTH     8     tid width
//  DEST_ENABLE  0     propagate tdest; 0 -> m tdest = 0
//  DEST_WIDTH   8     tdest width
//  USER_ENABLE  1     propagate tuser; 0 -> m tuser = 0
//  USER_WIDTH   1     tuser width
//  MODE         0     0 = explicit sel, 1 = round-robin arbitration
//  SEL_WIDTH    $clog2(S_COUNT)  sel / cur_sel width
// PORTS
//  clk            in   1                  clock; all logic on rising edge
//  rst_n          in   1                  synchronous reset, active low
//  s_axis_tdata   in   S_COUNT*DATA_WIDTH packed inputs, port i at [i*W +: W]
//  s_axis_tkeep   in   S_COUNT*KEEP_WIDTH
//  s_axis_tvalid  in   S_COUNT
//  s_axis_tready  out  S_COUNT
//  s_axis_tlast   in   S_COUNT
//  s_axis_tid     in   S_COUNT*ID_WIDTH
//  s_axis_tdest   in   S_COUNT*DEST_WIDTH
//  s_axis_tuser   in   S_COUNT*USER_WIDTH
//  m_axis_t*      out/in  per-field      output stream (tready is an input)
//  enable         in   1                  0 = pause: no grant, no accept
//  sel            in   SEL_WIDTH          requested port (MODE 0 only)
//  busy           out  1                  1 while a frame is granted (ACTIVE)
//  cur_sel        out  SEL_WIDTH          currently/last granted port
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; s_axis_tready=0; m_axis_tvalid=0; skid empty;
//   busy=0; cur_sel=0; RR pointer=S_COUNT-1, so port 0 has first priority.
//  FSM IDLE: s_axis_tready=0. Grant occurs when enable=1 and:
//   MODE 0: sel<S_COUNT and s_axis_tvalid[sel]=1.
//   MODE 1: any tvalid; pick first valid index after RR pointer (wrapping).
//   On grant: cur_sel<=port; busy<=1; RR pointer<=port; ->ACTIVE. Grant costs 1 cycle.
//  FSM ACTIVE: s_axis_tready[cur_sel] = enable & ~skid_full; other readies stay 0.
//   Accepting a beat with tlast=1 returns FSM to IDLE; busy<=0 the same edge.
//   Single-beat frames are legal. Per-frame cost: 1 grant cycle + N beat cycles.
//  sel changes and other-port tvalid are ignored while ACTIVE (no mid-frame switch).
//  enable=0 while ACTIVE stalls the input (tready=0) without losing the grant.
//   Beats already buffered still drain to m_axis.
//  MODE 0, sel>=S_COUNT: no grant; FSM stays IDLE.
//  Output: accepted beat appears on m_axis one cycle later (latency 1).
//   m_axis_t* held stable while tvalid=1 & tready=0.
//   Skid buffer is 2 entries; skid_full is registered, so input tready is independent of m_axis_tready.
//   With m_axis_tready=1 throughput is 1 beat/cycle; after a stall, no beat is lost or duplicated.
//  Disabled sideband fields are driven constant: tkeep all-ones; tid, tdest and tuser 0.
//  Reset mid-frame: buffered beats are discarded, FSM returns to IDLE, m_axis_tvalid=0 next cycle.
//   The partial frame is not completed; upstream must also reset.
// TESTING
//  T1 MODE0, sel=2, port2 sends 4-beat frame 0xA0..0xA3, m_tready=1
//     -> grant 1 cycle, then m_axis beats 0xA0..A3 on consecutive cycles, tlast on 0xA3, busy 1->0.
//  T2 MODE0, sel switched 2->1 after beat 1 of a 4-beat frame
//     -> all 4 port-2 beats delivered; port 1 granted only after tlast.
//  T3 MODE1, ports 0,1,3 each hold one 2-beat frame
//     -> output frame order 0,1,3; repeat the stimulus -> order 0,1,3 again (pointer wraps).
//  T4 random m_axis_tready (50%) over a 64-beat frame of incrementing data
//     -> output data 0..63 in order, no gaps or repeats, tvalid/data stable during stall.
//  T5 enable=0 for 3 cycles mid-frame
//     -> s_tready=0 those cycles, busy stays 1, frame resumes and completes intact.
//  T6 rst_n=0 one cycle mid-frame with 2 beats buffered
//     -> next cycle m_axis_tvalid=0, busy=0, cur_sel=0, all s_axis_tready=0.

Source files
------------

// File: rtl/axis_mux_pkt_n.sv
// Frame-aware N:1 AXI4-Stream mux. Input ports are switched only between packets, chosen by
// explicit sel or by round-robin. The output comes from a 2-entry skid buffer.
module axis_mux_pkt_n #(
  parameter int unsigned S_COUNT     = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned ID_ENABLE   = 0,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned DEST_ENABLE = 0,
  parameter int unsigned DEST_WIDTH  = 8,
  parameter int unsigned USER_ENABLE = 1,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned MODE        = 0,
  parameter int unsigned SEL_WIDTH   = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]   s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  input  logic                          enable,
  input  logic [SEL_WIDTH-1:0]          sel,
  output logic                          busy,
  output logic [SEL_WIDTH-1:0]          cur_sel
);

  localparam int unsigned PW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SEL_WIDTH-1:0]   rr_ptr;
  logic [1:0]             cnt;
  logic [PW-1:0]          slot0;
  logic [PW-1:0]          slot1;
  logic                   skid_full;
  logic                   accept;
  logic                   pop;
  logic                   grant;
  logic [SEL_WIDTH-1:0]   grant_port;

  logic [DATA_WIDTH-1:0]  dat_arr  [S_COUNT];
  logic [KEEP_WIDTH-1:0]  keep_arr [S_COUNT];
  logic [ID_WIDTH-1:0]    id_arr   [S_COUNT];
  logic [DEST_WIDTH-1:0]  dest_arr [S_COUNT];
  logic [USER_WIDTH-1:0]  user_arr [S_COUNT];

  logic [DATA_WIDTH-1:0]  in_data;
  logic [KEEP_WIDTH-1:0]  in_keep;
  logic [ID_WIDTH-1:0]    in_id;
  logic [DEST_WIDTH-1:0]  in_dest;
  logic [USER_WIDTH-1:0]  in_user;
  logic                   in_last;
  logic                   in_valid;
  logic [PW-1:0]          in_pl;

  for (genvar g = 0; g < S_COUNT; g++) begin : g_split
    assign dat_arr[g]  = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign keep_arr[g] = s_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH];
    assign id_arr[g]   = s_axis_tid[g*ID_WIDTH +: ID_WIDTH];
    assign dest_arr[g] = s_axis_tdest[g*DEST_WIDTH +: DEST_WIDTH];
    assign user_arr[g] = s_axis_tuser[g*USER_WIDTH +: USER_WIDTH];
  end

  // Disabled sidebands are forced to constants before they are buffered
  assign in_data  = dat_arr[cur_sel];
  assign in_keep  = (KEEP_ENABLE != 0) ? keep_arr[cur_sel] : '1;
  assign in_id    = (ID_ENABLE   != 0) ? id_arr[cur_sel]   : '0;
  assign in_dest  = (DEST_ENABLE != 0) ? dest_arr[cur_sel] : '0;
  assign in_user  = (USER_ENABLE != 0) ? user_arr[cur_sel] : '0;
  assign in_last  = s_axis_tlast[cur_sel];
  assign in_valid = s_axis_tvalid[cur_sel];
  assign in_pl    = {in_data, in_keep, in_last, in_id, in_dest, in_user};

  assign skid_full     = (cnt == 2'd2);
  assign m_axis_tvalid = (cnt != 2'd0);
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = slot0;

  assign accept = (state == ACTIVE) && enable && !skid_full && in_valid;
  assign pop    = m_axis_tvalid && m_axis_tready;

  always_comb begin
    s_axis_tready = '0;
    if (state == ACTIVE && enable && !skid_full) s_axis_tready[cur_sel] = 1'b1;
  end

  // Port selection for the next frame: explicit sel, or first valid port after rr_ptr
  always_comb begin
    int unsigned idx;
    grant      = 1'b0;
    grant_port = '0;
    idx        = 0;
    if (MODE == 0) begin
      if (enable && (32'(sel) < S_COUNT) && s_axis_tvalid[sel]) begin
        grant      = 1'b1;
        grant_port = sel;
      end
    end else begin
      for (int unsigned i = 1; i <= S_COUNT; i++) begin
        idx = (32'(rr_ptr) + i) % S_COUNT;
        if (!grant && enable && s_axis_tvalid[SEL_WIDTH'(idx)]) begin
          grant      = 1'b1;
          grant_port = SEL_WIDTH'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cur_sel <= '0;
      rr_ptr  <= SEL_WIDTH'(S_COUNT - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            cur_sel <= grant_port;
            rr_ptr  <= grant_port;
            busy    <= 1'b1;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (accept && in_last) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry buffer; slot0 is the head that drives m_axis
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= in_pl;
          else             slot1 <= in_pl;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: slot0 <= in_pl;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_mux_pkt_n.sv
// Scoreboard bench for axis_mux_pkt_n: a MODE 0 instance (dut0) and a MODE 1 instance (dut1).
module tb_axis_mux_pkt_n;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_err;

  logic [31:0]  d0 [4];
  logic [31:0]  d1 [4];
  logic [127:0] s_tdata0, s_tdata1;
  logic [3:0]   v0, v1, l0, l1, u0, u1, rdy0, rdy1;
  logic         en0, en1;
  logic [1:0]   sel0, sel1;
  logic [15:0]  keep_all;
  logic [31:0]  id_c, dst_c;

  logic [31:0]  md0, md1;
  logic [3:0]   mk0, mk1;
  logic         mv0, mv1, mr0, mr1, ml0, ml1, mu0, mu1;
  logic [7:0]   mid0, mid1, mdst0, mdst1;
  logic         busy0, busy1;
  logic [1:0]   cs0, cs1;
  logic [49:0]  mw0, mw1;

  logic [49:0]  exp_q0 [$];
  logic [49:0]  exp_q1 [$];
  int           hs0 [$];

  assign s_tdata0 = {d0[3], d0[2], d0[1], d0[0]};
  assign s_tdata1 = {d1[3], d1[2], d1[1], d1[0]};
  assign mw0 = {mdst0, mid0, mu0, ml0, md0};
  assign mw1 = {mdst1, mid1, mu1, ml1, md1};

  axis_mux_pkt_n #(.MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata0), .s_axis_tkeep(keep_all), .s_axis_tvalid(v0),
    .s_axis_tready(rdy0), .s_axis_tlast(l0), .s_axis_tid(id_c),
    .s_axis_tdest(dst_c), .s_axis_tuser(u0),
    .m_axis_tdata(md0), .m_axis_tkeep(mk0), .m_axis_tvalid(mv0),
    .m_axis_tready(mr0), .m_axis_tlast(ml0), .m_axis_tid(mid0),
    .m_axis_tdest(mdst0), .m_axis_tuser(mu0),
    .enable(en0), .sel(sel0), .busy(busy0), .cur_sel(cs0)
  );

  axis_mux_pkt_n #(.MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata1), .s_axis_tkeep(keep_all), .s_axis_tvalid(v1),
    .s_axis_tready(rdy1), .s_axis_tlast(l1), .s_axis_tid(id_c),
    .s_axis_tdest(dst_c), .s_axis_tuser(u1),
    .m_axis_tdata(md1), .m_axis_tkeep(mk1), .m_axis_tvalid(mv1),
    .m_axis_tready(mr1), .m_axis_tlast(ml1), .m_axis_tid(mid1),
    .m_axis_tdest(mdst1), .m_axis_tuser(mu1),
    .enable(en1), .sel(sel1), .busy(busy1), .cur_sel(cs1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Expected beats: tdest/tid disabled -> 0, tuser carries data bit 0
  task automatic expect_frame(input bit inst, input logic [31:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      logic [31:0] dat;
      logic [49:0] w;
      dat = base + 32'(b);
      w   = {16'h0, dat[0], (b == n - 1), dat};
      if (inst) exp_q1.push_back(w);
      else      exp_q0.push_back(w);
    end
  endtask

  task automatic drive(input bit inst, input logic [1:0] port, input logic [31:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      logic [31:0] dat;
      logic        acc;
      dat = base + 32'(b);
      if (inst) begin
        d1[port] = dat; l1[port] = (b == n - 1); u1[port] = dat[0]; v1[port] = 1'b1;
      end else begin
        d0[port] = dat; l0[port] = (b == n - 1); u0[port] = dat[0]; v0[port] = 1'b1;
      end
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge clk);
        acc = inst ? rdy1[port] : rdy0[port];
        @(posedge clk);
        #1;
      end
      chk("drv_accept", 64'(acc), 64'd1);
    end
    if (inst) begin v1[port] = 1'b0; l1[port] = 1'b0; end
    else      begin v0[port] = 1'b0; l0[port] = 1'b0; end
  endtask

  task automatic wait_drain(input bit inst);
    int sz;
    sz = inst ? exp_q1.size() : exp_q0.size();
    for (int t = 0; t < 300 && sz != 0; t++) begin
      @(negedge clk);
      sz = inst ? exp_q1.size() : exp_q0.size();
    end
    chk("drain_empty", 64'(sz), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard on every handshake and checks stability while stalled
  task automatic monitor(input bit inst);
    logic        stall;
    logic [49:0] held, w, e;
    logic        v, r;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      v = inst ? mv1 : mv0;
      r = inst ? mr1 : mr0;
      w = inst ? mw1 : mw0;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", 64'(v), 64'd1);
          chk("stall_data", 64'(w), 64'(held));
        end
        if (v && r) begin
          if ((inst ? exp_q1.size() : exp_q0.size()) == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_unexpected: got beat 0x%0h expected none (inst %0d)", w, inst);
          end else begin
            e = inst ? exp_q1.pop_front() : exp_q0.pop_front();
            chk(inst ? "sb_beat1" : "sb_beat0", 64'(w), 64'(e));
          end
          if (!inst) hs0.push_back(cyc);
        end
        stall = v && !r;
        held  = w;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    n_chk = 0; n_err = 0;
    for (int i = 0; i < 4; i++) begin d0[i] = '0; d1[i] = '0; end
    v0 = '0; v1 = '0; l0 = '0; l1 = '0; u0 = '0; u1 = '0;
    en0 = 1'b1; en1 = 1'b1; sel0 = 2'd0; sel1 = 2'd0;
    mr0 = 1'b1; mr1 = 1'b1;
    keep_all = '1; id_c = 32'hA5A5_A5A5; dst_c = 32'h5A5A_5A5A;
    fork
      monitor(1'b0);
      monitor(1'b1);
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_mvalid0", 64'(mv0), 64'd0);
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_cursel0", 64'(cs0), 64'd0);
    chk("rst_tready0", 64'(rdy0), 64'd0);
    chk("rst_tready1", 64'(rdy1), 64'd0);
    @(posedge clk); #1;

    // T1: sel=2, four beats, one grant cycle then back-to-back output
    sel0 = 2'd2;
    hs0.delete();
    expect_frame(1'b0, 32'hA0, 4);
    fork
      drive(1'b0, 2'd2, 32'hA0, 4);
      begin
        @(negedge clk);
        chk("t1_grant_busy", 64'(busy0), 64'd0);
        chk("t1_grant_tready", 64'(rdy0), 64'd0);
        @(negedge clk);
        chk("t1_busy", 64'(busy0), 64'd1);
        chk("t1_cursel", 64'(cs0), 64'd2);
        chk("t1_tready", 64'(rdy0), 64'b0100);
      end
    join
    @(negedge clk);
    chk("t1_busy_end", 64'(busy0), 64'd0);
    wait_drain(1'b0);
    chk("t1_hs_count", 64'(hs0.size()), 64'd4);
    if (hs0.size() == 4) chk("t1_consecutive", 64'(hs0[3] - hs0[0]), 64'd3);

    // T2: sel moves to port 1 mid-frame; port 2 frame must complete first
    expect_frame(1'b0, 32'hB0, 4);
    expect_frame(1'b0, 32'hC0, 1);
    fork
      drive(1'b0, 2'd2, 32'hB0, 4);
      drive(1'b0, 2'd1, 32'hC0, 1);
      begin
        repeat (3) @(posedge clk);
        #1 sel0 = 2'd1;
        @(negedge clk);
        chk("t2_cursel_hold", 64'(cs0), 64'd2);
        chk("t2_busy_hold", 64'(busy0), 64'd1);
      end
    join
    wait_drain(1'b0);

    // T3: round-robin over ports 0,1,3, twice
    for (int r = 0; r < 2; r++) begin
      logic [31:0] b;
      b = 32'h100 * 32'(r + 1);
      expect_frame(1'b1, b + 32'h10, 2);
      expect_frame(1'b1, b + 32'h20, 2);
      expect_frame(1'b1, b + 32'h30, 2);
      fork
        drive(1'b1, 2'd0, b + 32'h10, 2);
        drive(1'b1, 2'd1, b + 32'h20, 2);
        drive(1'b1, 2'd3, b + 32'h30, 2);
      join
      wait_drain(1'b1);
    end

    // T4: 64-beat frame against random downstream backpressure
    begin
      bit done;
      done = 1'b0;
      sel0 = 2'd0;
      expect_frame(1'b0, 32'h0, 64);
      fork
        begin
          drive(1'b0, 2'd0, 32'h0, 64);
          done = 1'b1;
        end
        while (!done) begin
          @(posedge clk);
          #1 mr0 = 1'($urandom_range(0, 1));
        end
      join
      mr0 = 1'b1;
      wait_drain(1'b0);
    end

    // T5: enable dropped for three cycles mid-frame
    sel0 = 2'd3;
    expect_frame(1'b0, 32'h50, 6);
    fork
      drive(1'b0, 2'd3, 32'h50, 6);
      begin
        repeat (3) @(posedge clk);
        #1 en0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("t5_tready_off", 64'(rdy0), 64'd0);
          chk("t5_busy_hold", 64'(busy0), 64'd1);
        end
        @(posedge clk);
        #1 en0 = 1'b1;
      end
    join
    wait_drain(1'b0);

    // T6: reset with two beats parked in the skid buffer
    mr0 = 1'b0;
    sel0 = 2'd0;
    d0[0] = 32'hEE; l0[0] = 1'b0; u0[0] = 1'b0; v0[0] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t6_mvalid_pre", 64'(mv0), 64'd1);
    chk("t6_skid_full", 64'(rdy0), 64'd0);
    chk("t6_busy_pre", 64'(busy0), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0; v0[0] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_mvalid", 64'(mv0), 64'd0);
    chk("t6_busy", 64'(busy0), 64'd0);
    chk("t6_cursel", 64'(cs0), 64'd0);
    chk("t6_tready", 64'(rdy0), 64'd0);
    mr0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("end_q0_empty", 64'(exp_q0.size()), 64'd0);
    chk("end_q1_empty", 64'(exp_q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
